// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_pkg.sv
// Shared types and constants for the 2-input cell BIST driver/checker.
package gf180mcu_fd_sc_mcu7t5v0__bist_pkg;

  localparam int unsigned NUM_VEC    = 4;
  localparam int unsigned VEC_W      = 2;
  localparam int unsigned ERR_CNT_W  = 8;
  localparam int unsigned SIG_W      = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned LOOP_W     = 8;
  localparam int unsigned LOOP_CMP_W = LOOP_W + 1;

  localparam logic [SIG_W-1:0] MISR_POLY = 8'h1D;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    FINISH
  } state_e;

  // One MISR step: shift, fold in the polynomial on MSB carry-out, xor in the response bit.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig, input logic d);
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : SIG_W'(0)) ^ SIG_W'(d);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__gate2_bist_if.sv
// Control/status and CUT stimulus/response bundle of the gate2 BIST.
// SIG is present only when GF180MCU_FD_SC_MCU7T5V0__BIST_SIGNATURE_EN is defined.
interface gf180mcu_fd_sc_mcu7t5v0__gate2_bist_if;
  import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;

  logic                 START;
  logic                 A1;
  logic                 A2;
  logic                 ZN;
  logic                 BUSY;
  logic                 DONE;
  logic                 PASS;
  logic [ERR_CNT_W-1:0] ERR_CNT;
  logic [NUM_VEC-1:0]   FAIL_VEC;

`ifdef GF180MCU_FD_SC_MCU7T5V0__BIST_SIGNATURE_EN
  logic [SIG_W-1:0]     SIG;

  modport slave  (input  START, ZN,
                  output A1, A2, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, SIG);
  modport master (output START, ZN,
                  input  A1, A2, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, SIG);
`else
  modport slave  (input  START, ZN,
                  output A1, A2, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC);
  modport master (output START, ZN,
                  input  A1, A2, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC);
`endif

endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_misr.sv
// 8-bit response signature register (x^8+x^4+x^3+x^2+1) with clear and enable.
module gf180mcu_fd_sc_mcu7t5v0__bist_misr
  import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      sig_q <= '0;
    end else if (en_i) begin
      sig_q <= misr_step(sig_q, d_i);
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__gate2_bist.sv
// Exhaustive BIST driver/checker for a 2-input combinational cell.
// Defining GF180MCU_FD_SC_MCU7T5V0__BIST_SIGNATURE_EN adds the SIG port and MISR.
module gf180mcu_fd_sc_mcu7t5v0__gate2_bist
  import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] TRUTH         = 4'b0111,
  parameter int unsigned        SETTLE_CYCLES = 2,
  parameter int unsigned        LOOPS         = 1
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  gf180mcu_fd_sc_mcu7t5v0__gate2_bist_if.slave   bist_if
);

  // SETTLE occupies SETTLE_CYCLES-1 cycles; with a single settle cycle it is skipped.
  localparam int unsigned SETTLE_HOLD = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0;
  localparam bit          SKIP_SETTLE = (SETTLE_CYCLES <= 1);

  state_e               state_q;
  logic [VEC_W-1:0]     idx_q;
  logic [LOOP_W-1:0]    loop_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 armed_q;
  logic                 a1_q;
  logic                 a2_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic [NUM_VEC-1:0]   fail_vec_q;

  logic                 launch_c;
  logic                 mismatch_c;
  logic                 last_c;
  logic [ERR_CNT_W-1:0] err_d;

  // START must be seen low in IDLE before it can launch again (no retrigger at DONE).
  assign launch_c   = (state_q == IDLE) && bist_if.START && armed_q;
  assign mismatch_c = (bist_if.ZN !== TRUTH[idx_q]);
  assign err_d      = (err_q == '1) ? err_q : err_q + ERR_CNT_W'(1);
  assign last_c     = (idx_q == VEC_W'(NUM_VEC - 1)) &&
                      ((LOOP_CMP_W'(loop_q) + LOOP_CMP_W'(1)) == LOOP_CMP_W'(LOOPS));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      loop_q     <= '0;
      cnt_q      <= '0;
      armed_q    <= 1'b1;
      a1_q       <= 1'b0;
      a2_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_vec_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (launch_c) begin
            err_q      <= '0;
            fail_vec_q <= '0;
            pass_q     <= 1'b0;
            idx_q      <= '0;
            loop_q     <= '0;
            armed_q    <= 1'b0;
            state_q    <= APPLY;
          end else if (!bist_if.START) begin
            armed_q <= 1'b1;
          end
        end
        APPLY: begin
          {a2_q, a1_q} <= idx_q;
          busy_q       <= 1'b1;
          cnt_q        <= CNT_W'(SETTLE_HOLD);
          state_q      <= SKIP_SETTLE ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        SAMPLE: begin
          if (mismatch_c) begin
            err_q             <= err_d;
            fail_vec_q[idx_q] <= 1'b1;
          end
          idx_q <= idx_q + VEC_W'(1);
          if (idx_q == VEC_W'(NUM_VEC - 1)) begin
            loop_q <= loop_q + LOOP_W'(1);
          end
          state_q <= last_c ? FINISH : APPLY;
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= (err_q == '0);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bist_if.A1       = a1_q;
  assign bist_if.A2       = a2_q;
  assign bist_if.BUSY     = busy_q;
  assign bist_if.DONE     = done_q;
  assign bist_if.PASS     = pass_q;
  assign bist_if.ERR_CNT  = err_q;
  assign bist_if.FAIL_VEC = fail_vec_q;

`ifdef GF180MCU_FD_SC_MCU7T5V0__BIST_SIGNATURE_EN
  logic sample_c;
  assign sample_c = (state_q == SAMPLE);

  gf180mcu_fd_sc_mcu7t5v0__bist_misr u_misr (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (launch_c),
    .en_i  (sample_c),
    .d_i   (bist_if.ZN),
    .sig_o (bist_if.SIG)
  );
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__gate2_bist.sv
// Directed bench for the gate2 BIST: NAND2 CUT model, stuck-at CUTs, reset abort, START hold.
module tb_gf180mcu_fd_sc_mcu7t5v0__gate2_bist;

  localparam int SETTLE = 2;

  typedef struct {
    logic       pass;
    logic [7:0] err;
    logic [3:0] fv;
    logic [7:0] sig;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_drv;
  logic [1:0] zn_mode;   // 0: golden NAND2, 1: stuck-at-1, 2: stuck-at-0
  int         sel;
  int         checks = 0;
  int         errors = 0;
  exp_t       sbq[$];

  gf180mcu_fd_sc_mcu7t5v0__gate2_bist_if bif0 ();
  gf180mcu_fd_sc_mcu7t5v0__gate2_bist_if bif1 ();

  function automatic logic cut(input logic [1:0] m, input logic a1, input logic a2);
    case (m)
      2'd1:    return 1'b1;
      2'd2:    return 1'b0;
      default: return ~(a1 & a2);
    endcase
  endfunction

  assign bif0.START = (sel == 0) && start_drv;
  assign bif1.START = (sel == 1) && start_drv;
  assign bif0.ZN    = cut(zn_mode, bif0.A1, bif0.A2);
  assign bif1.ZN    = cut(zn_mode, bif1.A1, bif1.A2);

  gf180mcu_fd_sc_mcu7t5v0__gate2_bist #(
    .TRUTH(4'b0111), .SETTLE_CYCLES(SETTLE), .LOOPS(1)
  ) dut0 (.CLK(clk), .RST(rst), .bist_if(bif0));

  gf180mcu_fd_sc_mcu7t5v0__gate2_bist #(
    .TRUTH(4'b0111), .SETTLE_CYCLES(SETTLE), .LOOPS(100)
  ) dut1 (.CLK(clk), .RST(rst), .bist_if(bif1));

  logic       o_a1, o_a2, o_busy, o_done, o_pass;
  logic [7:0] o_err;
  logic [3:0] o_fv;
  logic [7:0] o_sig;

  always_comb begin
    if (sel == 1) begin
      o_a1 = bif1.A1; o_a2 = bif1.A2; o_busy = bif1.BUSY; o_done = bif1.DONE;
      o_pass = bif1.PASS; o_err = bif1.ERR_CNT; o_fv = bif1.FAIL_VEC;
    end else begin
      o_a1 = bif0.A1; o_a2 = bif0.A2; o_busy = bif0.BUSY; o_done = bif0.DONE;
      o_pass = bif0.PASS; o_err = bif0.ERR_CNT; o_fv = bif0.FAIL_VEC;
    end
`ifdef GF180MCU_FD_SC_MCU7T5V0__BIST_SIGNATURE_EN
    o_sig = (sel == 1) ? bif1.SIG : bif0.SIG;
`else
    o_sig = 8'h00;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic d);
    logic fb;
    fb = s[7];
    s  = {s[6:0], d};
    if (fb) s = s ^ 8'b0001_1101;
    return s;
  endfunction

  // Reference result of a whole run against a NAND2 truth table.
  function automatic exp_t model(input logic [1:0] mode, input int loops);
    exp_t e;
    logic zn;
    e.err = 8'd0; e.fv = 4'd0; e.sig = 8'd0;
    for (int l = 0; l < loops; l++) begin
      for (int v = 0; v < 4; v++) begin
        zn = cut(mode, v[0], v[1]);
        if (zn !== ~(v[0] & v[1])) begin
          if (e.err != 8'hFF) e.err = e.err + 8'd1;
          e.fv[v] = 1'b1;
        end
        e.sig = misr_ref(e.sig, zn);
      end
    end
    e.pass = (e.err == 8'd0);
    e.lat  = 4 * loops * (SETTLE + 1) + 1;
    return e;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_a"},    {30'd0, o_a2, o_a1}, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_err"},  o_err, 0);
    chk({tag, "_fv"},   o_fv, 0);
`ifdef GF180MCU_FD_SC_MCU7T5V0__BIST_SIGNATURE_EN
    chk({tag, "_sig"},  o_sig, 0);
`endif
  endtask

  task automatic run_and_check(input string tag, input int which, input logic [1:0] mode,
                               input int loops, input bit hold);
    exp_t e;
    int   n;
    bit   seen;
    sel     = which;
    zn_mode = mode;
    sbq.push_back(model(mode, loops));
    @(negedge clk); start_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy_k"}, o_busy, 0);
    if (!hold) start_drv = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 5000) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == 1) begin
        chk({tag, "_busy_k1"}, o_busy, 1);
        chk({tag, "_vec0"}, {30'd0, o_a2, o_a1}, 0);
      end
      if (o_done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    e = sbq.pop_front();
    chk({tag, "_latency"}, n, e.lat);
    chk({tag, "_pass"}, o_pass, e.pass);
    chk({tag, "_err"}, o_err, e.err);
    chk({tag, "_fv"}, o_fv, e.fv);
    chk({tag, "_busy_end"}, o_busy, 0);
    chk({tag, "_a_hold"}, {30'd0, o_a2, o_a1}, 3);
`ifdef GF180MCU_FD_SC_MCU7T5V0__BIST_SIGNATURE_EN
    chk({tag, "_sig"}, o_sig, e.sig);
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, o_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_drv = 1'b0; zn_mode = 2'd0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 0; #0 check_reset_state("rst0");
    sel = 1; #0 check_reset_state("rst1");
    sel = 0;
    rst = 1'b0;

    run_and_check("golden", 0, 2'd0, 1, 1'b0);
    run_and_check("stuck1", 0, 2'd1, 1, 1'b0);
    run_and_check("stuck0_l100", 1, 2'd2, 100, 1'b0);

    // Reset abort: RST sampled at edge k+5 of a run.
    sel = 0; zn_mode = 2'd1;
    @(negedge clk); start_drv = 1'b1;
    @(posedge clk);
    @(negedge clk); start_drv = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_mid", o_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("abort");
    rst = 1'b0;
    run_and_check("after_abort", 0, 2'd0, 1, 1'b0);

    // START held through the whole run: no retrigger, then re-arm.
    run_and_check("hold", 0, 2'd0, 1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_no_retrigger", o_busy, 0);
    end
    start_drv = 1'b0;
    @(negedge clk);
    run_and_check("rearm", 0, 2'd0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
